// File: rtl/v1_filter_event_ctrl_pkg.sv
// Shared settings and types for the v1 filter event controller and the downstream packer.
package v1_filter_event_ctrl_pkg;

   localparam int SIZE_FILTER_DATA = 16;
   localparam int SIZE_TS          = 32;
   localparam int SIZE_LOST        = 16;
   localparam int MAX_RISE         = 64;
   localparam int DEAD_TIME        = 16;
   localparam logic [SIZE_FILTER_DATA-1:0] DEFAULT_THRESHOLD = 16'd100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      OUT   = 2'd2,
      DEAD  = 2'd3
   } v1_ev_state_t;

   typedef struct packed {
      logic [SIZE_FILTER_DATA-1:0] amplitude;
      logic [SIZE_TS-1:0]          timestamp;
      logic                        timeout;
   } v1_event_t;

endpackage

// File: rtl/v1_filter_event_ctrl.sv
// Arms on a threshold crossing of the signed filter stream, tracks the pulse peak and
// hands one event record per pulse downstream, followed by a dead time.
module v1_filter_event_ctrl
   import v1_filter_event_ctrl_pkg::*;
#(
   parameter int MAX_RISE  = v1_filter_event_ctrl_pkg::MAX_RISE,
   parameter int DEAD_TIME = v1_filter_event_ctrl_pkg::DEAD_TIME
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [SIZE_FILTER_DATA-1:0] threshold,
   input  logic [SIZE_FILTER_DATA-1:0] filter_data,
   output logic                        event_valid,
   input  logic                        event_ready,
   output logic [SIZE_FILTER_DATA-1:0] event_amplitude,
   output logic [SIZE_TS-1:0]          event_time,
   output logic                        event_timeout,
   output logic                        busy,
   output logic [SIZE_LOST-1:0]        lost_count,
   output v1_ev_state_t                debug_state
);

   // Handshake: the record transfers on any rising edge where event_valid && event_ready;
   // valid never drops and the record never changes until that transfer happens.

   localparam int RW = $clog2(MAX_RISE + 1);
   localparam int DW = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;

   v1_ev_state_t                state;
   logic [SIZE_TS-1:0]          ts;
   logic [SIZE_TS-1:0]          t0;
   logic [SIZE_FILTER_DATA-1:0] peak;
   logic [RW-1:0]               rise_cnt;
   logic [DW-1:0]               dead_cnt;
   logic                        prev_above;
   v1_event_t                   ev_q;

   logic above;
   logic rising;
   logic rise_limit;
   logic lost_event;

   assign above      = $signed(filter_data) > $signed(threshold);
   assign rising     = above && !prev_above;
   assign rise_limit = (rise_cnt == RW'(MAX_RISE));
   assign lost_event = rising && ((state == OUT) || (state == DEAD));

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         ts          <= '0;
         t0          <= '0;
         peak        <= '0;
         rise_cnt    <= '0;
         dead_cnt    <= '0;
         prev_above  <= 1'b0;
         ev_q        <= '0;
         event_valid <= 1'b0;
         busy        <= 1'b0;
         lost_count  <= '0;
      end else begin
         ts         <= ts + 1'b1;
         prev_above <= above;
         if (lost_event && (lost_count != '1))
            lost_count <= lost_count + 1'b1;

         case (state)
            IDLE: begin
               if (enable && above) begin
                  state    <= TRACK;
                  busy     <= 1'b1;
                  peak     <= filter_data;
                  t0       <= ts;
                  rise_cnt <= RW'(1);
               end
            end
            TRACK: begin
               // The closing sample (below threshold or at the rise limit) never feeds the peak.
               if (rise_limit || !above) begin
                  state          <= OUT;
                  event_valid    <= 1'b1;
                  ev_q.amplitude <= peak;
                  ev_q.timestamp <= t0;
                  ev_q.timeout   <= rise_limit;
               end else begin
                  if ($signed(filter_data) > $signed(peak))
                     peak <= filter_data;
                  rise_cnt <= rise_cnt + 1'b1;
               end
            end
            OUT: begin
               if (event_ready) begin
                  event_valid <= 1'b0;
                  if (DEAD_TIME == 0) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state    <= DEAD;
                     dead_cnt <= DW'(DEAD_TIME);
                  end
               end
            end
            DEAD: begin
               if (dead_cnt <= DW'(1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  dead_cnt <= dead_cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign event_amplitude = ev_q.amplitude;
   assign event_time      = ev_q.timestamp;
   assign event_timeout   = ev_q.timeout;
   assign debug_state     = state;

endmodule

// File: doc/v1_filter_event_ctrl.md
# v1_filter_event_ctrl

Event controller that sequences readout of the v1 trapezoidal shaping filter output. It watches the signed filter stream and arms on a threshold crossing. It tracks the pulse peak and timestamps the trigger, then hands one event record per pulse to the downstream packer over a valid/ready handshake. After each event it enforces a dead time before re-arming and counts pulses lost while busy.

## Interface
- `SIZE_FILTER_DATA`, 16, filter sample width (two's complement); shared package constant.
- `SIZE_TS`, 32, timestamp counter width.
- `MAX_RISE`, 64, maximum cycles spent tracking one pulse before a forced close.
- `DEAD_TIME`, 16, cycles held off after an event is accepted; 0 allowed.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  arms triggering; sampled only in IDLE.
- `threshold`  in  SIZE_FILTER_DATA  signed trigger level; static while enable=1.
- `filter_data`  in  SIZE_FILTER_DATA  signed filter output, one sample per clk.
- `event_valid`  out  1  event record available.
- `event_ready`  in  1  downstream accepts the record.
- `event_amplitude`  out  SIZE_FILTER_DATA  signed peak value.
- `event_time`  out  SIZE_TS  timestamp of the trigger sample.
- `event_timeout`  out  1  pulse closed by the MAX_RISE limit.
- `busy`  out  1  state is not IDLE.
- `lost_count`  out  16  saturating count of pulses missed while busy.

## Operation
- The timestamp counter `ts` is 0 after reset and increments every cycle. It wraps modulo 2^SIZE_TS.
- Crossing: `above = filter_data > threshold`, a signed compare. A rising crossing requires `above` with the previous sample not above.
- States are IDLE, TRACK, OUT and DEAD.
- IDLE -> TRACK when `enable && above`. This is a level condition, so a sample already above threshold triggers. On the transition, latch `peak = filter_data`, `t0 = ts` and `rise_cnt = 1`.
- In TRACK, when `filter_data > peak`, set `peak = filter_data`; equal values do not update the peak.
  - TRACK -> OUT on the first sample with `!above`. The closing sample is not compared against the peak.
  - TRACK -> OUT when `rise_cnt == MAX_RISE`, which sets `event_timeout`. If both conditions hold in the same cycle, the timeout flag is set.
- In OUT, `event_valid=1`. `event_amplitude`, `event_time` and `event_timeout` stay stable until a transfer occurs (`event_valid && event_ready`). There is no timeout in OUT; backpressure may last indefinitely.
- On the transfer cycle, go to DEAD with `dead_cnt = DEAD_TIME`. If DEAD_TIME = 0, go straight to IDLE.
- In DEAD, decrement `dead_cnt` each cycle and go to IDLE when it reaches 1.
- `lost_count` increments on every rising crossing seen in OUT or DEAD. It saturates at 16'hFFFF and clears only on reset.
- `enable` deasserting outside IDLE does not abort the current event.

## Timing
- Reset values: state IDLE, `event_valid=0`, `event_amplitude=0`, `event_time=0`, `event_timeout=0`, `busy=0`, `lost_count=0`, `ts=0`, previous-sample flag = 0.
- Reset asserted in any state returns to IDLE on the next edge. A pending event is discarded and not counted as lost.
- All outputs are registered.
- Trigger sample at cycle t: `busy=1` from t+1, and `event_time` equals `ts` at cycle t.
- Closing sample at cycle c: `event_valid=1` from c+1.
- Transfer at cycle a: `event_valid=0` at a+1.
- DEAD_TIME = D > 0: IDLE is reached at a+1+D, and a trigger is accepted at the earliest in that cycle.
- Minimum event spacing is therefore 2 + D cycles plus the pulse width.
- `event_ready` may be high before `event_valid`, so the transfer can happen in the first OUT cycle.

## Structure
- `package_settings`: `SIZE_FILTER_DATA`.
- `v1_parameters`: `MAX_RISE`, `DEAD_TIME` and default `threshold`.
- A shared package holds `typedef enum logic [1:0] {IDLE, TRACK, OUT, DEAD} v1_ev_state_t` and a packed `v1_event_t` struct {amplitude, time, timeout} for reuse by the packer.
- Single module, no sub-modules. The peak tracker is inline.

## Test plan
- Basic pulse: threshold 100; samples 50, 150, 300, 250, 90 with the first one at ts=10; ready held high. Required: one event with amplitude 300, time 11, timeout 0, valid exactly one cycle.
- Backpressure: the same pulse with ready low for 20 cycles. Required: valid and all fields stable for 20 cycles, transfer on the first ready cycle, then 16 DEAD cycles before IDLE.
- Lost pulses: two rising crossings of threshold during OUT/DEAD. Required: `lost_count` = 2 and no extra events.
- Timeout: a constant sample of 500 for 100 cycles with MAX_RISE = 64. Required: event with amplitude 500, timeout 1.
- Negative/signed data: threshold -50; samples -100, -20, -10, -60. Required: amplitude -10.
- Reset mid-TRACK and mid-OUT: all outputs return to reset values on the next cycle; `lost_count` = 0; the next pulse is processed normally.
